// File: rtl/axi4_burst_master_if.sv
// Bundle of the command/stream side and the full AXI4 master channel set used by axi4_burst_master.
// The master modport is the burst engine's view; the slave modport is the surrounding logic/memory view.
interface axi4_burst_master_if #(
  parameter int DATA = 64,
  parameter int ADDR = 32
);
  // Every stream and AXI channel transfers exactly on a cycle where valid and ready are both high at the clock edge.
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR-1:0]   cmd_addr;
  logic [7:0]        cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA-1:0]   wr_data;
  logic [DATA/8-1:0] wr_strb;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA-1:0]   rd_data;
  logic              rd_last;

  logic              done;
  logic [1:0]        done_resp;
  logic              busy;

  logic [ADDR-1:0]   M_AXI_AWADDR;
  logic [7:0]        M_AXI_AWLEN;
  logic [2:0]        M_AXI_AWSIZE;
  logic [1:0]        M_AXI_AWBURST;
  logic              M_AXI_AWLOCK;
  logic [3:0]        M_AXI_AWCACHE;
  logic [2:0]        M_AXI_AWPROT;
  logic [3:0]        M_AXI_AWQOS;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY;

  logic [DATA-1:0]   M_AXI_WDATA;
  logic [DATA/8-1:0] M_AXI_WSTRB;
  logic              M_AXI_WLAST;
  logic              M_AXI_WVALID;
  logic              M_AXI_WREADY;

  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;

  logic [ADDR-1:0]   M_AXI_ARADDR;
  logic [7:0]        M_AXI_ARLEN;
  logic [2:0]        M_AXI_ARSIZE;
  logic [1:0]        M_AXI_ARBURST;
  logic              M_AXI_ARLOCK;
  logic [3:0]        M_AXI_ARCACHE;
  logic [2:0]        M_AXI_ARPROT;
  logic [3:0]        M_AXI_ARQOS;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;

  logic [DATA-1:0]   M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RLAST;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data, wr_strb,
    output wr_ready,
    input  rd_ready,
    output rd_valid, rd_data, rd_last,
    output done, done_resp, busy,
    output M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
           M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
           M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data, wr_strb,
    input  wr_ready,
    output rd_ready,
    input  rd_valid, rd_data, rd_last,
    input  done, done_resp, busy,
    input  M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
           M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
           M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-command AXI4 INCR burst master: one read or write burst per command, data streamed
// straight through to/from the AXI W and R channels, completion reported with the worst response.
module axi4_burst_master #(
  parameter int C_M_AXI_DATA_WIDTH = 64,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_MAX_BURST        = 16
) (
  input  logic                 M_AXI_ACLK,
  input  logic                 M_AXI_ARESETN,
  axi4_burst_master_if.master  bus,
  output logic [2:0]           dbg_state
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SZ = $clog2(DW / 8);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WADDR = 3'd2,
    S_WDATA = 3'd3,
    S_WRESP = 3'd4,
    S_RADDR = 3'd5,
    S_RDATA = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [1:0]    resp_q, resp_d;
  logic [1:0]    rmax_q, rmax_d;
  logic          rerr_q, rerr_d;

  logic          cmd_ready_c;
  logic          aw_valid_c;
  logic          ar_valid_c;
  logic          w_active;
  logic          r_active;
  logic          b_ready_c;
  logic          done_c;
  logic          last_beat;
  logic          too_long;
  logic          crosses_4k;
  logic [AW-1:0] burst_end;

  assign last_beat  = (cnt_q == len_q);
  assign too_long   = ({1'b0, len_q} > 9'(C_MAX_BURST - 1));
  assign burst_end  = addr_q + ((AW'({1'b0, len_q}) + AW'(1)) << SZ) - AW'(1);
  assign crosses_4k = (burst_end[AW-1:12] != addr_q[AW-1:12]);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      resp_q  <= 2'b00;
      rmax_q  <= 2'b00;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rmax_q  <= rmax_d;
      rerr_q  <= rerr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    rmax_d      = rmax_q;
    rerr_d      = rerr_q;
    cmd_ready_c = 1'b0;
    aw_valid_c  = 1'b0;
    ar_valid_c  = 1'b0;
    w_active    = 1'b0;
    r_active    = 1'b0;
    b_ready_c   = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready_c = 1'b1;
        if (bus.cmd_valid) begin
          we_d    = bus.cmd_we;
          addr_d  = {bus.cmd_addr[AW-1:SZ], {SZ{1'b0}}};
          len_d   = bus.cmd_len;
          state_d = S_CHECK;
        end
      end

      // Illegal bursts complete with SLVERR without touching the bus.
      S_CHECK: begin
        cnt_d  = '0;
        rmax_d = 2'b00;
        rerr_d = 1'b0;
        if (too_long || crosses_4k) begin
          resp_d  = 2'b10;
          state_d = S_DONE;
        end else begin
          resp_d  = 2'b00;
          state_d = we_q ? S_WADDR : S_RADDR;
        end
      end

      S_WADDR: begin
        aw_valid_c = 1'b1;
        if (bus.M_AXI_AWREADY) state_d = S_WDATA;
      end

      S_WDATA: begin
        w_active = 1'b1;
        if (bus.wr_valid && bus.M_AXI_WREADY) begin
          if (last_beat) state_d = S_WRESP;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end

      S_WRESP: begin
        b_ready_c = 1'b1;
        if (bus.M_AXI_BVALID) begin
          resp_d  = bus.M_AXI_BRESP;
          state_d = S_DONE;
        end
      end

      S_RADDR: begin
        ar_valid_c = 1'b1;
        if (bus.M_AXI_ARREADY) state_d = S_RDATA;
      end

      // The burst length is ours, not the slave's: a misplaced RLAST is flagged, never obeyed.
      S_RDATA: begin
        r_active = 1'b1;
        if (bus.M_AXI_RVALID && bus.rd_ready) begin
          rmax_d = (bus.M_AXI_RRESP > rmax_q) ? bus.M_AXI_RRESP : rmax_q;
          if (bus.M_AXI_RLAST != last_beat) rerr_d = 1'b1;
          if (last_beat) begin
            resp_d  = rerr_d ? 2'b10 : rmax_d;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_c & M_AXI_ARESETN;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_c;
  assign bus.done_resp = resp_q;

  assign bus.M_AXI_AWADDR  = addr_q;
  assign bus.M_AXI_AWLEN   = len_q;
  assign bus.M_AXI_AWSIZE  = 3'(SZ);
  assign bus.M_AXI_AWBURST = 2'b01;
  assign bus.M_AXI_AWLOCK  = 1'b0;
  assign bus.M_AXI_AWCACHE = 4'b0011;
  assign bus.M_AXI_AWPROT  = 3'b000;
  assign bus.M_AXI_AWQOS   = 4'b0000;
  assign bus.M_AXI_AWVALID = aw_valid_c;

  assign bus.M_AXI_WDATA   = bus.wr_data;
  assign bus.M_AXI_WSTRB   = bus.wr_strb;
  assign bus.M_AXI_WLAST   = w_active & last_beat;
  assign bus.M_AXI_WVALID  = w_active & bus.wr_valid;
  assign bus.wr_ready      = w_active & bus.M_AXI_WREADY;

  assign bus.M_AXI_BREADY  = b_ready_c;

  assign bus.M_AXI_ARADDR  = addr_q;
  assign bus.M_AXI_ARLEN   = len_q;
  assign bus.M_AXI_ARSIZE  = 3'(SZ);
  assign bus.M_AXI_ARBURST = 2'b01;
  assign bus.M_AXI_ARLOCK  = 1'b0;
  assign bus.M_AXI_ARCACHE = 4'b0011;
  assign bus.M_AXI_ARPROT  = 3'b000;
  assign bus.M_AXI_ARQOS   = 4'b0000;
  assign bus.M_AXI_ARVALID = ar_valid_c;

  assign bus.rd_valid      = r_active & bus.M_AXI_RVALID;
  assign bus.M_AXI_RREADY  = r_active & bus.rd_ready;
  assign bus.rd_data       = bus.M_AXI_RDATA;
  assign bus.rd_last       = r_active & last_beat;

  assign dbg_state = state_q;
endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: directed vector table, hand-built corner sequences and
// randomized bursts, all driven cycle by cycle against a bench-side AXI slave and stream source/sink.
module tb_axi4_burst_master;
  localparam int DW   = 64;
  localparam int AW   = 32;
  localparam int MAXB = 16;
  localparam int NB   = DW / 8;
  localparam logic [16:0] FIXED_AX = {3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  axi4_burst_master_if #(.DATA(DW), .ADDR(AW)) bus ();

  axi4_burst_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_MAX_BURST(MAXB)
  ) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [1:0]    rresp_tab[256];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    int          len;
    logic [1:0]  bresp;
    int          stall;
    logic [31:0] exp_addr;
    logic        exp_rej;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.cmd_valid     = 1'b0;
    bus.cmd_we        = 1'b0;
    bus.cmd_addr      = '0;
    bus.cmd_len       = '0;
    bus.wr_valid      = 1'b0;
    bus.wr_data       = '0;
    bus.wr_strb       = '0;
    bus.rd_ready      = 1'b0;
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BRESP   = 2'b00;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = 2'b00;
    bus.M_AXI_RLAST   = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
  endtask

  // Reference rules: aligned start, legal length, no 4 KB crossing.
  function automatic logic model_reject(input logic [31:0] addr, input int len);
    longint al, en;
    al = longint'(addr) & ~longint'(NB - 1);
    en = al + longint'((len + 1) * NB) - 1;
    return (len > MAXB - 1) || ((al >> 12) != (en >> 12));
  endfunction

  function automatic logic [1:0] model_resp(input logic we, input logic rej, input logic [1:0] bresp,
                                            input int len, input int rlast_beat);
    logic [1:0] m;
    if (rej) return 2'b10;
    if (we)  return bresp;
    if (rlast_beat != len) return 2'b10;
    m = 2'b00;
    for (int i = 0; i <= len; i++) if (rresp_tab[i] > m) m = rresp_tab[i];
    return m;
  endfunction

  function automatic logic rnd_bit(input int stall);
    return (stall == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
  endfunction

  task automatic run_txn(input logic we, input logic [31:0] addr, input int len, input logic [1:0] bresp,
                         input int stall, input int rlast_beat, input int abort_beat,
                         input logic [31:0] exp_addr, input logic exp_rej, input logic [1:0] exp_resp,
                         input string tag);
    int cyc, w_cnt, r_cnt, rd_cnt, aw_cnt, ar_cnt, hs_cyc, first_ax, viol, done_cnt;
    logic bv, rv, finished, up_hs, ax_hs;
    logic [DW-1:0] wd, rd, got;
    cyc = 0; w_cnt = 0; r_cnt = 0; rd_cnt = 0; aw_cnt = 0; ar_cnt = 0;
    hs_cyc = -1; first_ax = -1; viol = 0; done_cnt = 0;
    bv = 1'b0; rv = 1'b0; finished = 1'b0;
    wd = {$urandom, $urandom};
    rd = {$urandom, $urandom};
    exp_q.delete();

    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_len   = 8'(len);
    #1;
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = $urandom;
    bus.cmd_len   = 8'($urandom);
    cyc = 1;

    while (!finished && cyc < 500) begin
      bus.M_AXI_AWREADY = rnd_bit(stall);
      bus.M_AXI_ARREADY = rnd_bit(stall);
      bus.M_AXI_WREADY  = rnd_bit(stall);
      bus.wr_valid      = (w_cnt <= len) && rnd_bit(stall);
      bus.wr_data       = wd;
      bus.wr_strb       = wd[NB-1:0];
      if (!bv && aw_cnt > 0 && w_cnt == len + 1 && rnd_bit(stall)) bv = 1'b1;
      bus.M_AXI_BVALID  = bv;
      bus.M_AXI_BRESP   = bresp;
      if (!rv && ar_cnt > 0 && r_cnt <= len && rnd_bit(stall)) rv = 1'b1;
      bus.M_AXI_RVALID  = rv;
      bus.M_AXI_RDATA   = rd;
      bus.M_AXI_RRESP   = rresp_tab[r_cnt[7:0]];
      bus.M_AXI_RLAST   = (r_cnt == rlast_beat);
      bus.rd_ready      = rnd_bit(stall);
      #1;

      if (bus.M_AXI_BREADY && !(aw_cnt > 0 && w_cnt == len + 1 && hs_cyc < 0)) viol++;
      if (bus.M_AXI_RREADY && !(ar_cnt > 0 && r_cnt <= len)) viol++;
      if (!bus.busy) viol++;
      if ((bus.M_AXI_AWVALID || bus.M_AXI_ARVALID) && first_ax < 0) first_ax = cyc;

      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        aw_cnt++;
        chk({tag, "_awaddr"}, bus.M_AXI_AWADDR, exp_addr);
        chk({tag, "_awlen"}, bus.M_AXI_AWLEN, 64'(len));
        chk({tag, "_awfixed"}, {bus.M_AXI_AWSIZE, bus.M_AXI_AWBURST, bus.M_AXI_AWLOCK,
                                bus.M_AXI_AWCACHE, bus.M_AXI_AWPROT, bus.M_AXI_AWQOS}, FIXED_AX);
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        ar_cnt++;
        chk({tag, "_araddr"}, bus.M_AXI_ARADDR, exp_addr);
        chk({tag, "_arlen"}, bus.M_AXI_ARLEN, 64'(len));
        chk({tag, "_arfixed"}, {bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST, bus.M_AXI_ARLOCK,
                                bus.M_AXI_ARCACHE, bus.M_AXI_ARPROT, bus.M_AXI_ARQOS}, FIXED_AX);
      end

      up_hs = bus.wr_valid && bus.wr_ready;
      ax_hs = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
      if (up_hs || ax_hs) chk({tag, "_w_pass"}, up_hs, ax_hs);
      if (up_hs) exp_q.push_back(wd);
      if (ax_hs) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : ~bus.M_AXI_WDATA;
        chk({tag, "_wdata"}, bus.M_AXI_WDATA, got);
        chk({tag, "_wstrb"}, bus.M_AXI_WSTRB, got[NB-1:0]);
        chk({tag, "_wlast"}, bus.M_AXI_WLAST, (w_cnt == len));
        w_cnt++;
        wd = {$urandom, $urandom};
      end

      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin
        bv = 1'b0;
        hs_cyc = cyc;
      end

      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) begin
        exp_q.push_back(rd);
        r_cnt++;
        rv = 1'b0;
        rd = {$urandom, $urandom};
        if (r_cnt == len + 1) hs_cyc = cyc;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        got = (exp_q.size() > 0) ? exp_q.pop_front() : ~bus.rd_data;
        chk({tag, "_rd_data"}, bus.rd_data, got);
        chk({tag, "_rd_last"}, bus.rd_last, (rd_cnt == len));
        rd_cnt++;
      end

      if (bus.done) begin
        done_cnt++;
        finished = 1'b1;
        chk({tag, "_done_resp"}, bus.done_resp, exp_resp);
        chk({tag, "_done_lat"}, 64'(cyc), exp_rej ? 64'd2 : 64'(hs_cyc + 1));
        chk({tag, "_no_cmd_in_done"}, bus.cmd_ready, 0);
      end

      if (abort_beat >= 0 && w_cnt == abort_beat) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_reset_outs"}, {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID,
                                   bus.M_AXI_BREADY, bus.M_AXI_RREADY, bus.wr_ready, bus.rd_valid,
                                   bus.cmd_ready, bus.busy, bus.done, bus.done_resp}, 0);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          if (bus.done || bus.busy) done_cnt++;
        end
        chk({tag, "_no_done_in_reset"}, 64'(done_cnt), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end

      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end

    if (!finished) chk({tag, "_timeout"}, 1, 0);
    if (!exp_rej) chk({tag, "_ax_latency"}, 64'(first_ax), 2);
    chk({tag, "_aw_count"}, 64'(aw_cnt), (we && !exp_rej) ? 1 : 0);
    chk({tag, "_ar_count"}, 64'(ar_cnt), (!we && !exp_rej) ? 1 : 0);
    chk({tag, "_beats"}, {32'(w_cnt), 32'(rd_cnt)},
        {(we && !exp_rej) ? 32'(len + 1) : 32'd0, (!we && !exp_rej) ? 32'(len + 1) : 32'd0});
    chk({tag, "_protocol"}, 64'(viol), 0);
    chk({tag, "_leftover"}, 64'(exp_q.size()), 0);

    idle_inputs();
    @(posedge clk); #1;
    chk({tag, "_after_done"}, {bus.busy, bus.cmd_ready, bus.done}, 3'b010);
  endtask

  initial begin
    logic        we, rej;
    logic [31:0] addr;
    int          len, rl;
    logic [1:0]  br;

    idle_inputs();
    for (int i = 0; i < 256; i++) rresp_tab[i] = 2'b00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY,
                       bus.M_AXI_RREADY, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.cmd_ready,
                       bus.done, bus.busy, bus.done_resp}, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", bus.cmd_ready, 1);

    vecs[0] = '{1'b1, 32'h0000_1000, 3,    2'b00, 0, 32'h0000_1000, 1'b0, 2'b00};
    vecs[1] = '{1'b0, 32'h0000_2008, 7,    2'b00, 1, 32'h0000_2008, 1'b0, 2'b00};
    vecs[2] = '{1'b1, 32'h0000_0FF8, 1,    2'b00, 0, 32'h0000_0FF8, 1'b1, 2'b10};
    vecs[3] = '{1'b0, 32'h0000_0FF8, 1,    2'b00, 0, 32'h0000_0FF8, 1'b1, 2'b10};
    vecs[4] = '{1'b1, 32'h0000_0000, MAXB, 2'b00, 0, 32'h0000_0000, 1'b1, 2'b10};
    vecs[5] = '{1'b0, 32'h0000_0000, MAXB, 2'b00, 0, 32'h0000_0000, 1'b1, 2'b10};
    vecs[6] = '{1'b1, 32'h0000_1003, 0,    2'b00, 0, 32'h0000_1000, 1'b0, 2'b00};
    vecs[7] = '{1'b1, 32'h0000_3000, 15,   2'b01, 1, 32'h0000_3000, 1'b0, 2'b01};
    vecs[8] = '{1'b0, 32'h0000_1F80, 15,   2'b00, 0, 32'h0000_1F80, 1'b0, 2'b00};
    vecs[9] = '{1'b1, 32'h0000_1F88, 15,   2'b00, 0, 32'h0000_1F88, 1'b1, 2'b10};

    for (int v = 0; v < 10; v++)
      run_txn(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].bresp, vecs[v].stall, vecs[v].len, -1,
              vecs[v].exp_addr, vecs[v].exp_rej, vecs[v].exp_resp, $sformatf("vec%0d", v));

    rresp_tab[0] = 2'b00; rresp_tab[1] = 2'b10; rresp_tab[2] = 2'b00;
    run_txn(1'b0, 32'h0000_4000, 2, 2'b00, 0, 2, -1, 32'h0000_4000, 1'b0, 2'b10, "rresp_max");
    for (int i = 0; i < 256; i++) rresp_tab[i] = 2'b00;
    run_txn(1'b0, 32'h0000_5000, 3, 2'b00, 1, 1, -1, 32'h0000_5000, 1'b0, 2'b10, "early_rlast");
    run_txn(1'b1, 32'h0000_6000, 3, 2'b00, 0, 3, 1, 32'h0000_6000, 1'b0, 2'b00, "abort");
    run_txn(1'b1, 32'h0000_6000, 3, 2'b00, 0, 3, -1, 32'h0000_6000, 1'b0, 2'b00, "after_reset");

    for (int t = 0; t < 40; t++) begin
      we   = 1'($urandom_range(0, 1));
      addr = {20'($urandom_range(0, 7)), 12'($urandom_range(0, 4095))};
      len  = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXB, MAXB + 4) : $urandom_range(0, MAXB - 1);
      br   = 2'($urandom_range(0, 3));
      rl   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len + 1) : len;
      for (int i = 0; i < 256; i++)
        rresp_tab[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rej = model_reject(addr, len);
      run_txn(we, addr, len, br, 1, rl, -1, addr & ~32'(NB - 1), rej,
              model_resp(we, rej, br, len, rl), $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_burst_master.md
Name: axi4_burst_master

Overview:
- Parametrised AXI4 burst master replacing the tie-off master on the accelerator's memory port.
- Accepts one read or write command at a time from the NN accelerator control logic.
- Issues a single INCR burst of up to C_MAX_BURST beats.
- Streams write data in and read data out over valid/ready interfaces, then reports completion with the burst's worst-case response.

Parameters:
C_M_AXI_DATA_WIDTH, 64, AXI data width in bits (32, 64 or 128)
C_M_AXI_ADDR_WIDTH, 32, AXI address width in bits
C_MAX_BURST, 16, maximum beats per burst (1..256)

Ports:
M_AXI_ACLK  in  1  clock
M_AXI_ARESETN  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_we  in  1  1=write, 0=read
cmd_addr  in  ADDR  byte start address
cmd_len  in  8  beats minus one
wr_valid / wr_ready  in / out  1  write-data stream handshake
wr_data  in  DATA  write beat
wr_strb  in  DATA/8  byte enables
rd_valid / rd_ready  out / in  1  read-data stream handshake
rd_data  out  DATA  read beat
rd_last  out  1  final read beat
done  out  1  one-cycle completion pulse
done_resp  out  2  worst response of the burst, valid with done
busy  out  1  high from command acceptance until the cycle after done
M_AXI_AW*, M_AXI_W*, M_AXI_B*, M_AXI_AR*, M_AXI_R*  full AXI4 master channel set, same names, widths and directions as the existing master

Behaviour:
- Reset: all VALID outputs, cmd_ready, wr_ready, rd_valid, rd_last, done and busy are 0. done_resp is 0. Address and length registers are 0. The FSM enters IDLE.
- Reset is asynchronous. Assertion mid-burst abandons the transfer immediately, with no completion pulse.
- Fixed channel fields:
  - AxSIZE = log2(DATA/8); AxBURST = INCR.
  - AxLOCK = 0; AxCACHE = 4'b0011; AxPROT = 0; AxQOS = 0.
  - AxADDR = cmd_addr with the low log2(DATA/8) bits forced to 0.
  - AxLEN = registered cmd_len.
- FSM states: IDLE, CHECK, WADDR, WDATA, WRESP, RADDR, RDATA, DONE.
- IDLE: cmd_ready = 1. On the handshake, register we/addr/len and go to CHECK.
- CHECK (1 cycle): reject the command if len > C_MAX_BURST-1, or if the burst crosses a 4 KB boundary (aligned start + (len+1)*DATA/8 - 1 differs in bits [ADDR-1:12]). A rejected command issues no AXI traffic: done_resp = 2'b10, go to DONE. Otherwise go to WADDR or RADDR.
- WADDR: AWVALID = 1 until AWREADY, then go to WDATA. AWVALID and AW fields are held stable while waiting.
- WDATA:
  - WVALID = wr_valid, wr_ready = WREADY; pass-through, no buffering.
  - A beat counter increments per W handshake.
  - WLAST = 1 exactly when count == len.
  - After the last handshake, go to WRESP.
- WRESP: BREADY = 1. On BVALID, done_resp = BRESP, go to DONE.
- RADDR: ARVALID = 1 until ARREADY, then go to RDATA.
- RDATA:
  - rd_valid = RVALID, RREADY = rd_ready, rd_data = RDATA.
  - rd_last = 1 on beat count == len.
  - done_resp accumulates the numeric max of RRESP over all beats.
  - If RLAST disagrees with beat count == len on any beat, done_resp is forced to 2'b10.
  - Leave RDATA after beat len is accepted; an early RLAST does not end the burst.
- DONE: done = 1 for one cycle, go to IDLE. A new command is accepted no earlier than the cycle after DONE.
- Latency: the command handshake is followed by AWVALID/ARVALID 2 cycles later. done follows the B handshake, or the last R handshake, by 1 cycle.
- Backpressure: zero-wait slaves sustain one beat per cycle. Stalls on any channel never drop or duplicate beats.
- BREADY and RREADY are 0 outside WRESP and RDATA respectively.

Test Plan:
- Write, addr 0x1000, len 3, zero-wait slave -> AWLEN = 3, AWSIZE = 3, 4 W beats, WLAST on beat 4 only, BRESP 0 -> done with done_resp = 00, one cycle after B handshake.
- Read, addr 0x2008, len 7, random RVALID and rd_ready stalls -> 8 beats in order, rd_last on the 8th only, done_resp = 00.
- Read, len 2, RRESP = 00, 10, 00 -> done_resp = 10. Separately, RLAST asserted on beat 2 of 4 -> all 4 beats delivered, done_resp = 10.
- Addr 0x0FF8, len 1, 64-bit data (crosses 4 KB) -> no AWVALID/ARVALID, done_resp = 10. Same result for len = C_MAX_BURST.
- ARESETN low during WDATA beat 2 -> all VALIDs 0 asynchronously, no done. A subsequent write then completes normally.
- Addr 0x1003, write len 0 -> AWADDR = 0x1000, single beat with WLAST = 1.
